// File: rtl/lsu_stage.sv
// Execute-to-writeback load/store stage: forwards ALU results, or runs one
// req/ack data-memory transaction with byte-lane strobes and load extension.
module lsu_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic                      is_load,
   input  logic                      is_store,
   input  logic [2:0]                funct3,
   input  logic [REG_ADDR_WIDTH-1:0] rd_in,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [3:0]                mem_wstrb,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_ack,
   output logic                      wb_valid,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic                      misaligned,
   output logic                      o_dbg_state
);

   // Handshake: an op transfers on a rising edge where in_valid && in_ready;
   // a memory request completes on the first edge where mem_req && mem_ack.
   typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t                    r_state;
   logic                      r_is_load;
   logic                      r_unsigned;
   logic [1:0]                r_size;
   logic [1:0]                r_off;
   logic [REG_ADDR_WIDTH-1:0] r_rd;

   logic                      w_accept;
   logic                      w_is_mem;
   logic [1:0]                w_off;
   logic [1:0]                w_size;
   logic                      w_misaligned;
   logic [DATA_WIDTH-1:0]     w_wdata;
   logic [3:0]                w_wstrb;
   logic [DATA_WIDTH-1:0]     w_rd_shift;
   logic [DATA_WIDTH-1:0]     w_ld_data;

   assign in_ready    = (r_state == S_IDLE);
   assign o_dbg_state = r_state;
   assign w_accept    = in_valid && in_ready;
   assign w_is_mem    = is_load || is_store;
   assign w_off       = alu_result[1:0];

   // Undefined width codes (011, 11x) fall into the word case.
   always_comb begin
      w_size = SZ_W;
      case (funct3[1:0])
         2'b00:   w_size = SZ_B;
         2'b01:   w_size = SZ_H;
         default: w_size = SZ_W;
      endcase
   end

   assign w_misaligned = ((w_size == SZ_H) && w_off[0]) ||
                         ((w_size == SZ_W) && (w_off != 2'b00));

   always_comb begin
      w_wdata = store_data;
      w_wstrb = 4'b1111;
      case (w_size)
         SZ_B: begin
            w_wdata = {4{store_data[7:0]}};
            w_wstrb = 4'b0001 << w_off;
         end
         SZ_H: begin
            w_wdata = {2{store_data[15:0]}};
            w_wstrb = 4'b0011 << w_off;
         end
         default: begin
            w_wdata = store_data;
            w_wstrb = 4'b1111;
         end
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend to full width.
   assign w_rd_shift = mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ld_data = mem_rdata;
      case (r_size)
         SZ_B:    w_ld_data = {{(DATA_WIDTH-8){~r_unsigned & w_rd_shift[7]}},
                               w_rd_shift[7:0]};
         SZ_H:    w_ld_data = {{(DATA_WIDTH-16){~r_unsigned & w_rd_shift[15]}},
                               w_rd_shift[15:0]};
         default: w_ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_is_load  <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= SZ_B;
         r_off      <= 2'b00;
         r_rd       <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= 4'b0000;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rd      <= '0;
         misaligned <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         misaligned <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (!w_is_mem) begin
                     wb_valid <= 1'b1;
                     wb_data  <= alu_result;
                     wb_rd    <= rd_in;
                  end else if (w_misaligned) begin
                     misaligned <= 1'b1;
                  end else begin
                     mem_req    <= 1'b1;
                     mem_we     <= is_store;
                     mem_addr   <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                     mem_wdata  <= is_store ? w_wdata : '0;
                     mem_wstrb  <= is_store ? w_wstrb : 4'b0000;
                     r_is_load  <= is_load;
                     r_unsigned <= funct3[2];
                     r_size     <= w_size;
                     r_off      <= w_off;
                     r_rd       <= rd_in;
                     r_state    <= S_MEM;
                  end
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'b0000;
                  r_state   <= S_IDLE;
                  if (r_is_load) begin
                     wb_valid <= 1'b1;
                     wb_data  <= w_ld_data;
                     wb_rd    <= r_rd;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: inputs change and outputs are sampled on the
// falling edge, so each step() is exactly one rising edge seen by the DUT.
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [4:0]  rd_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        misaligned;
   logic        o_dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   lsu_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .store_data(store_data), .is_load(is_load),
      .is_store(is_store), .funct3(funct3), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_rd(wb_rd), .misaligned(misaligned), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] rd);
      in_valid   = 1'b1;
      is_load    = ld;
      is_store   = st;
      funct3     = f3;
      alu_result = addr;
      store_data = sd;
      rd_in      = rd;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
   endtask

   // Zero-wait load: accept, one request cycle with ack, then writeback.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] exp);
      drive_op(1'b1, 1'b0, f3, addr, 32'h0, rd);
      step();
      idle_in();
      check({tag, "_req"},   {31'b0, mem_req}, 32'd1);
      check({tag, "_we"},    {31'b0, mem_we}, 32'd0);
      check({tag, "_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
      check({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check({tag, "_wbv"},   {31'b0, wb_valid}, 32'd1);
      check({tag, "_data"},  wb_data, exp);
      check({tag, "_rd"},    {27'b0, wb_rd}, {27'b0, rd});
      check({tag, "_req0"},  {31'b0, mem_req}, 32'd0);
      step();
      check({tag, "_wbv0"},  {31'b0, wb_valid}, 32'd0);
   endtask

   task automatic do_misaligned(input string tag, input logic ld, input logic [2:0] f3,
                                input logic [31:0] addr);
      drive_op(ld, ~ld, f3, addr, 32'h1234_5678, 5'd9);
      step();
      idle_in();
      check({tag, "_mis"},   {31'b0, misaligned}, 32'd1);
      check({tag, "_req"},   {31'b0, mem_req}, 32'd0);
      check({tag, "_wbv"},   {31'b0, wb_valid}, 32'd0);
      check({tag, "_rdy"},   {31'b0, in_ready}, 32'd1);
      step();
      check({tag, "_mis0"},  {31'b0, misaligned}, 32'd0);
      check({tag, "_req0"},  {31'b0, mem_req}, 32'd0);
   endtask

   // Zero-wait store with hand-computed lane data and strobes.
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb);
      drive_op(1'b0, 1'b1, f3, addr, sd, 5'd7);
      step();
      idle_in();
      check({tag, "_req"},   {31'b0, mem_req}, 32'd1);
      check({tag, "_we"},    {31'b0, mem_we}, 32'd1);
      check({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
      check({tag, "_wdata"}, mem_wdata, exp_wdata);
      check({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check({tag, "_req0"},  {31'b0, mem_req}, 32'd0);
      check({tag, "_wbv"},   {31'b0, wb_valid}, 32'd0);
      check({tag, "_rdy"},   {31'b0, in_ready}, 32'd1);
   endtask

   logic [31:0] pt_data [3] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000};

   initial begin
      // Reset held with hostile inputs active.
      rst        = 1'b1;
      mem_ack    = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd3);
      step();
      step();
      rst     = 1'b0;
      mem_ack = 1'b0;
      idle_in();
      check("rst_rdy",   {31'b0, in_ready}, 32'd1);
      check("rst_req",   {31'b0, mem_req}, 32'd0);
      check("rst_we",    {31'b0, mem_we}, 32'd0);
      check("rst_addr",  mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
      check("rst_wbv",   {31'b0, wb_valid}, 32'd0);
      check("rst_wbd",   wb_data, 32'h0);
      check("rst_wbrd",  {27'b0, wb_rd}, 32'h0);
      check("rst_mis",   {31'b0, misaligned}, 32'd0);
      check("rst_state", {31'b0, o_dbg_state}, 32'd0);

      // Pass-through burst, one result per cycle.
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b0, 1'b0, 3'b000, pt_data[i], 32'h0, 5'(i + 1));
         step();
         check("pt_wbv",  {31'b0, wb_valid}, 32'd1);
         check("pt_data", wb_data, pt_data[i]);
         check("pt_rd",   {27'b0, wb_rd}, i + 1);
         check("pt_req",  {31'b0, mem_req}, 32'd0);
      end
      idle_in();
      step();
      check("pt_wbv0", {31'b0, wb_valid}, 32'd0);

      // SB at 0x1003, two wait cycles before ack.
      drive_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd4);
      step();
      idle_in();
      for (int w = 0; w < 3; w++) begin
         check("sb_req",   {31'b0, mem_req}, 32'd1);
         check("sb_we",    {31'b0, mem_we}, 32'd1);
         check("sb_addr",  mem_addr, 32'h0000_1000);
         check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
         check("sb_wstrb", {28'b0, mem_wstrb}, 32'h8);
         check("sb_rdy",   {31'b0, in_ready}, 32'd0);
         check("sb_state", {31'b0, o_dbg_state}, 32'd1);
         if (w == 2) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;
      check("sb_req0", {31'b0, mem_req}, 32'd0);
      check("sb_rdy1", {31'b0, in_ready}, 32'd1);
      check("sb_wbv",  {31'b0, wb_valid}, 32'd0);

      do_store("sh", 3'b001, 32'h0000_1002, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100);
      do_store("sw", 3'b010, 32'h0000_1004, 32'h1234_5678, 32'h1234_5678, 4'b1111);

      // Loads from a word of 0x80F17F00.
      do_load("lh",  3'b001, 32'h0000_2002, 32'h80F1_7F00, 5'd5,  32'hFFFF_80F1);
      do_load("lhu", 3'b101, 32'h0000_2002, 32'h80F1_7F00, 5'd6,  32'h0000_80F1);
      do_load("lb",  3'b000, 32'h0000_2001, 32'h80F1_7F00, 5'd8,  32'h0000_007F);
      do_load("lb3", 3'b000, 32'h0000_2003, 32'h80F1_7F00, 5'd10, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_2003, 32'h80F1_7F00, 5'd11, 32'h0000_0080);
      do_load("lw",  3'b010, 32'h0000_2000, 32'h80F1_7F00, 5'd0,  32'h80F1_7F00);
      do_load("lx",  3'b111, 32'h0000_2000, 32'hCAFE_0001, 5'd12, 32'hCAFE_0001);

      do_misaligned("mis_lw", 1'b1, 3'b010, 32'h0000_3002);
      do_misaligned("mis_sh", 1'b0, 3'b001, 32'h0000_3001);

      // Reset while waiting for ack; a late ack must be ignored.
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd13);
      step();
      idle_in();
      check("rm_req", {31'b0, mem_req}, 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rm_req0", {31'b0, mem_req}, 32'd0);
      check("rm_wbv",  {31'b0, wb_valid}, 32'd0);
      check("rm_rdy",  {31'b0, in_ready}, 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_5555;
      step();
      mem_ack = 1'b0;
      check("rm_late_wbv", {31'b0, wb_valid}, 32'd0);
      check("rm_late_req", {31'b0, mem_req}, 32'd0);
      do_load("rm_next", 3'b010, 32'h0000_4004, 32'h0BAD_F00D, 5'd14, 32'h0BAD_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Execute-to-writeback stage that sits directly downstream of the ALU and consumes its `result` as either a writeback value or an effective memory address.
- Non-memory ops: registers the ALU result through to writeback.
- Loads/stores: runs one data-memory transaction over a req/ack handshake. Stores get byte-lane strobes; loads get lane extraction and sign/zero extension.
- Misaligned accesses are trapped without touching memory.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDR_WIDTH, 32, width of the memory address bus.
- REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents an op.
- in_ready  output  1  stage can accept; high only in IDLE.
- alu_result  input  DATA_WIDTH  ALU output; address for memory ops, writeback value otherwise.
- store_data  input  DATA_WIDTH  rs2 value for stores.
- is_load  input  1  op is a load.
- is_store  input  1  op is a store; is_load and is_store are never both high.
- funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_in  input  REG_ADDR_WIDTH  destination register.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable, valid while mem_req is high.
- mem_addr  output  ADDR_WIDTH  word-aligned address (low 2 bits are 0).
- mem_wdata  output  DATA_WIDTH  store data, replicated into lanes.
- mem_wstrb  output  4  byte strobes.
- mem_rdata  input  DATA_WIDTH  load data; valid when mem_ack is high.
- mem_ack  input  1  completes the request.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_data  output  DATA_WIDTH  writeback value.
- wb_rd  output  REG_ADDR_WIDTH  writeback register.
- misaligned  output  1  one-cycle trap pulse.

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, wb_valid, misaligned = 0; mem_addr, mem_wdata, wb_data, wb_rd = 0; mem_wstrb = 0000. Reset wins over every other event, including mid-transaction: the request drops at the reset edge and the pending op is discarded with no writeback.
- States:
  - IDLE: in_ready = 1.
  - MEM: waiting for mem_ack; in_ready = 0.
- Accept: in_valid && in_ready at a rising edge.
- Pass-through (neither load nor store): next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd_in. State stays IDLE, so back-to-back accepts give one result per cycle.
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00. B/BU is always aligned.
- Misaligned accept: next cycle misaligned=1 for one cycle. No mem_req, no wb_valid, stay IDLE.
- Aligned memory accept: next cycle mem_req=1, mem_addr={alu_result[ADDR_WIDTH-1:2],2'b00}; state goes to MEM.
  - mem_addr, mem_we, mem_wdata and mem_wstrb hold stable until ack.
  - mem_ack is ignored while mem_req is low.
  - Ack may arrive in the first cycle mem_req is high (zero wait); any number of wait cycles is allowed.
- Store:
  - mem_we=1.
  - B: wdata = byte replicated ×4; wstrb = 0001 << off.
  - H: wdata = half replicated ×2; wstrb = 0011 << off.
  - W: wdata = store_data; wstrb = 1111.
  - At the ack edge: mem_req=0, state IDLE, no wb_valid.
- Load:
  - mem_we=0, wstrb=0000.
  - At the ack edge, mem_rdata is captured and the selected lane extracted (byte at off*8, half at off*8).
  - Sign-extend for B/H; zero-extend for BU/HU/W.
  - Next cycle wb_valid=1, wb_data=result, wb_rd=latched rd; mem_req=0; state IDLE.
- A new op may be accepted in the same cycle wb_valid is high.
- rd_in = 0 still produces wb_valid; writeback suppression belongs to the register file.
- Undefined funct3 (011, 11x) on a memory op: treated as W.

Test Plan:
- Reset: assert rst for 2 cycles with mem_ack=1 and in_valid=1 -> all outputs 0 and in_ready=1 after release.
- Pass-through burst: 3 back-to-back ops with alu_result 0x1, 0xDEADBEEF, 0x0 and rd 1,2,3 -> wb_valid high for 3 consecutive cycles with matching wb_data/wb_rd, mem_req never asserted.
- SB at addr 0x1003, store_data 0x000000A5, ack after 2 wait cycles -> mem_addr 0x1000, wdata 0xA5A5A5A5, wstrb 1000, signals stable across waits, in_ready=0 until the ack edge.
- Loads at addr 0x2002 with mem_rdata 0x80F17F00, zero-wait ack:
  - LH -> wb_data 0xFFFF80F1.
  - LHU -> wb_data 0x000080F1.
  - LB at 0x2001 -> 0x0000007F.
- Misaligned: LW at 0x3002 and SH at 0x3001 -> misaligned pulse of 1 cycle each, no mem_req, no wb_valid.
- Reset mid-MEM: LW issued, rst asserted while waiting for ack -> mem_req=0 next edge, no wb_valid, a late mem_ack is ignored, and the next op proceeds normally.
